muldiv_seq: RTL and testbench

// - Multi-cycle RV32M controller/datapath beside the execute-stage ALU: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
// - Accepts one op from execute via valid/ready; iterates radix-2 shift-add / restoring division; returns one result.
// - Drives stall_o so the decode/execute pipeline holds while an op is in flight; flush_i aborts on branch/JALR redirect.

---
 rtl/muldiv_pkg.sv | 52 +++++
 rtl/muldiv_if.sv | 37 +++
 rtl/muldiv_div_step.sv | 38 +++
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and constants for the RV32M multi-cycle
//            multiply/divide unit.
//            - XLEN / CNT_W  : datapath width and iteration-counter width
//            - muldiv_op_e   : M-extension op, funct3 encoding
//            - muldiv_state_e: controller states
//            - is_signed_op1/op2, is_div_op helpers
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN  = 32;
    // Derived from XLEN; must reach XLEN itself, hence the +1.
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    // rs1 is interpreted as signed
    function automatic logic is_signed_op1(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic is_signed_op2(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // funct3[2] splits multiply from divide/remainder
    function automatic logic is_div_op(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Purpose  : Request/response bundle between execute and the mul/div unit.
//            master = execute/writeback side, slave = muldiv_seq.
//            req_valid/req_ready/req_op/operand1/operand2 : request handshake
//            flush_i                                       : abort in-flight op
//            rsp_valid/rsp_ready/rsp_result               : response handshake
//            stall_o                                       : pipeline hold
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_if;
    import muldiv_pkg::*;

    logic             req_valid;
    logic             req_ready;
    muldiv_op_e       req_op;
    logic [XLEN-1:0]  operand1;
    logic [XLEN-1:0]  operand2;
    logic             flush_i;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic             stall_o;

    modport master (
        output req_valid, req_op, operand1, operand2, flush_i, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, stall_o
    );

    modport slave (
        input  req_valid, req_op, operand1, operand2, flush_i, rsp_ready,
        output req_ready, rsp_valid, rsp_result, stall_o
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_div_step
// Purpose  : One combinational restoring-division step on magnitudes.
//            i_rem     : partial remainder in
//            i_quo     : remaining dividend bits (MSB next), quotient bits
//                        shift in at the LSB
//            i_divisor : divisor magnitude
//            o_rem     : partial remainder out
//            o_quo     : shifted dividend/quotient register out
// Revision : 1.0  initial release
// ============================================================================
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  wire logic [XLEN-1:0] i_rem,
    input  wire logic [XLEN-1:0] i_quo,
    input  wire logic [XLEN-1:0] i_divisor,
    output logic      [XLEN-1:0] o_rem,
    output logic      [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_borrow;

    always_comb begin
        w_shift  = {i_rem, i_quo[XLEN-1]};
        w_borrow = (w_shift < {1'b0, i_divisor});
        // When no borrow the true difference is below the divisor, so the
        // XLEN-bit modular subtraction is exact.
        w_diff   = w_shift[XLEN-1:0] - i_divisor;
        o_rem    = w_borrow ? w_shift[XLEN-1:0] : w_diff;
        o_quo    = {i_quo[XLEN-2:0], ~w_borrow};
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Multi-cycle RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//            Radix-2 shift-add multiply and restoring divide on magnitudes,
//            sign fix-up on the final step, one result per accepted op.
// Ports    : clk    - core clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - muldiv_if.slave (request, response, flush, stall)
// Config   : MULDIV_FAST_MUL_EN - when defined, MUL* ops complete in one
//            cycle through a combinational multiplier; divide unchanged.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    muldiv_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     r_state, w_state_next;
    muldiv_op_e        r_op, w_op_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_s1, w_s1_next;       // rs1 negative (signed ops only)
    logic              r_s2, w_s2_next;       // rs2 negative (signed ops only)
    // MUL: {partial product hi, remaining multiplier}; DIV: {remainder, quotient}
    logic [2*XLEN-1:0] r_acc, w_acc_next;
    logic [XLEN-1:0]   r_opnd, w_opnd_next;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]   r_result, w_result_next;

    logic              w_ready;
    logic              w_accept;
    logic              w_in_s1, w_in_s2;
    logic [XLEN-1:0]   w_in_mag1, w_in_mag2;
    logic              w_div_zero, w_div_ovf;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_acc, w_mul_prod;
    logic [XLEN-1:0]   w_div_rem, w_div_quo, w_div_q_fix, w_div_r_fix;

    assign w_ready  = (r_state == S_IDLE);
    // A flush in the same cycle as a request blocks the accept.
    assign w_accept = bus.req_valid & w_ready & ~bus.flush_i;

    assign w_in_s1    = is_signed_op1(bus.req_op) & bus.operand1[XLEN-1];
    assign w_in_s2    = is_signed_op2(bus.req_op) & bus.operand2[XLEN-1];
    assign w_in_mag1  = w_in_s1 ? -bus.operand1 : bus.operand1;
    assign w_in_mag2  = w_in_s2 ? -bus.operand2 : bus.operand2;
    assign w_div_zero = (bus.operand2 == '0);
    assign w_div_ovf  = (bus.operand1 == c_int_min) & (&bus.operand2);

    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the {carry, hi, lo} chain right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc  = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_mul_prod = (r_s1 ^ r_s2) ? -w_mul_acc : w_mul_acc;

    muldiv_div_step u_div_step (
        .i_rem     (r_acc[2*XLEN-1:XLEN]),
        .i_quo     (r_acc[XLEN-1:0]),
        .i_divisor (r_opnd),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_div_q_fix = (r_s1 ^ r_s2) ? -w_div_quo : w_div_quo;
    assign w_div_r_fix = r_s1 ? -w_div_rem : w_div_rem;

`ifdef MULDIV_FAST_MUL_EN
    // Operands sign-extended to 2*XLEN; the low 2*XLEN bits of the unsigned
    // product equal the two's-complement signed/unsigned product.
    logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
    assign w_fast_a    = {{XLEN{w_in_s1}}, bus.operand1};
    assign w_fast_b    = {{XLEN{w_in_s2}}, bus.operand2};
    assign w_fast_prod = w_fast_a * w_fast_b;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_cnt_next    = r_cnt;
        w_s1_next     = r_s1;
        w_s2_next     = r_s2;
        w_acc_next    = r_acc;
        w_opnd_next   = r_opnd;
        w_result_next = r_result;

        if (bus.flush_i) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_next = '0;
                    if (w_accept) begin
                        w_op_next = bus.req_op;
                        w_s1_next = w_in_s1;
                        w_s2_next = w_in_s2;
                        if (is_div_op(bus.req_op)) begin
                            w_acc_next  = {{XLEN{1'b0}}, w_in_mag1};
                            w_opnd_next = w_in_mag2;
                            if (w_div_zero) begin
                                w_state_next  = S_DONE;
                                w_result_next = ((bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU))
                                              ? '1 : bus.operand1;
                            end else if (w_div_ovf && ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM))) begin
                                w_state_next  = S_DONE;
                                w_result_next = (bus.req_op == OP_DIV) ? c_int_min : '0;
                            end else begin
                                w_state_next = S_DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            w_state_next  = S_DONE;
                            w_result_next = (bus.req_op == OP_MUL) ? w_fast_prod[XLEN-1:0]
                                                                   : w_fast_prod[2*XLEN-1:XLEN];
`else
                            w_acc_next   = {{XLEN{1'b0}}, w_in_mag2};
                            w_opnd_next  = w_in_mag1;
                            w_state_next = S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    w_acc_next = w_mul_acc;
                    w_cnt_next = r_cnt + CNT_W'(1);
                    // Final step: sign fix-up and word select in the same edge.
                    if (r_cnt == c_cnt_last) begin
                        w_state_next  = S_DONE;
                        w_result_next = (r_op == OP_MUL) ? w_mul_prod[XLEN-1:0]
                                                         : w_mul_prod[2*XLEN-1:XLEN];
                    end
                end
                S_DIV: begin
                    w_acc_next = {w_div_rem, w_div_quo};
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == c_cnt_last) begin
                        w_state_next  = S_DONE;
                        w_result_next = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? w_div_q_fix
                                                                                : w_div_r_fix;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_cnt    <= w_cnt_next;
            r_s1     <= w_s1_next;
            r_s2     <= w_s2_next;
            r_acc    <= w_acc_next;
            r_opnd   <= w_opnd_next;
            r_result <= w_result_next;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = (r_state == S_DONE);
    assign bus.rsp_result = (r_state == S_DONE) ? r_result : '0;
    assign bus.stall_o    = (bus.req_valid & ~w_ready) | (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq: directed vector table,
//            flush/reset/backpressure sequences, and random ops checked
//            against a plain-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit c_fast = 1'b1;
`else
    localparam bit c_fast = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    muldiv_if bus();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the ISA rules, using 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input muldiv_op_e op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input muldiv_op_e op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
            if (b == 32'd0) return 1;
            if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
        return c_fast ? 1 : 33;
    endfunction

    // One full transaction: accept, wait for result, hold rsp_ready low
    // for `hold` cycles, consume, then confirm return to idle.
    task automatic run_op(input string name, input muldiv_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int lat;
        logic [31:0] first;
        @(negedge clk);
        check({name, "/ready_before"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.operand1  = a;
        bus.operand2  = b;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 100) begin
            check({name, "/busy_stall_ready"}, {bus.stall_o, bus.req_ready}, 2'b10);
            @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, lat, exp_lat);
        check({name, "/result"}, bus.rsp_result, exp_res);
        first = bus.rsp_result;
        repeat (hold) begin
            @(negedge clk);
            check({name, "/hold_valid_ready_stall"}, {bus.rsp_valid, bus.req_ready, bus.stall_o}, 3'b101);
            check({name, "/hold_stable"}, bus.rsp_result, first);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({name, "/after_consume"}, {bus.rsp_valid, bus.req_ready, bus.stall_o}, 3'b010);
    endtask

    typedef struct {
        muldiv_op_e  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[21];

    initial begin
        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{OP_REM,    32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{OP_MUL,    32'd3,         32'd4,         32'd12,        33};
        vecs[13] = '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[14] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[15] = '{OP_MULH,   32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 33};
        vecs[16] = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[17] = '{OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[18] = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[19] = '{OP_REMU,   32'd9,         32'd0,         32'd9,         1};
        vecs[20] = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_MUL;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.flush_i   = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #12;
        check("reset/ready_valid_stall", {bus.req_ready, bus.rsp_valid, bus.stall_o}, 3'b100);
        check("reset/result", bus.rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            int lat;
            lat = vecs[i].lat;
            if (c_fast && !vecs[i].op[2]) lat = 1;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, lat, 0);
        end

        // Backpressure: result held for 5 cycles
        run_op("hold5_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 5);
        run_op("hold5_special", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 5);

        // Flush in the middle of a divide
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.operand1  = 32'hFFFF_FFF9;
        bus.operand2  = 32'd2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            check("flush/busy_no_valid", {bus.rsp_valid, bus.stall_o}, 2'b01);
        end
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush/idle_after", {bus.req_ready, bus.rsp_valid, bus.stall_o}, 3'b100);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("flush/no_late_valid", bus.rsp_valid, 1'b0);
        end
        run_op("flush/next_mul", OP_MUL, 32'd3, 32'd4, 32'd12, c_fast ? 1 : 33, 0);

        // Flush together with a request in IDLE: request is dropped
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.operand1  = 32'd5;
        bus.operand2  = 32'd0;
        bus.flush_i   = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush_i   = 1'b0;
        check("flush_req/not_accepted", {bus.req_ready, bus.rsp_valid, bus.stall_o}, 3'b100);

        // Flush and rsp_ready together in DONE
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("flush_done/valid", {bus.rsp_valid, bus.rsp_result}, {1'b1, 32'hFFFF_FFFF});
        bus.flush_i   = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.flush_i   = 1'b0;
        bus.rsp_ready = 1'b0;
        check("flush_done/idle", {bus.req_ready, bus.rsp_valid, bus.stall_o}, 3'b100);
        @(negedge clk);
        check("flush_done/stays_idle", bus.rsp_valid, 1'b0);

        // Asynchronous reset mid-divide
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.operand1  = 32'd100;
        bus.operand2  = 32'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("areset/busy_before", bus.stall_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("areset/ready_valid_stall", {bus.req_ready, bus.rsp_valid, bus.stall_o}, 3'b100);
        check("areset/result", bus.rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("areset/next_div", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            muldiv_op_e  op;
            logic [31:0] a, b;
            int          sel;
            op  = muldiv_op_e'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) b = -$urandom_range(1, 15);
            run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, ref_result(op, a, b),
                   ref_latency(op, a, b), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
